// File: rtl/bm_memory_pkg.sv
// ---------------------------------------------------------------------------
// bm_memory_pkg
// Shared definitions for the parametrised benchmark memory:
//   - clear-sequencer state encoding (CLEAR / IDLE)
//   - clog2 helper used to size the sweep counter
// No ports.
// ---------------------------------------------------------------------------
package bm_memory_pkg;

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_IDLE  = 1'b1;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned v;
      res = 0;
      v   = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/bm_param_memory_if.sv
// ---------------------------------------------------------------------------
// bm_param_memory_if
// Access bus of the benchmark memory.
//   master : drives clear, we/waddr/wdata, re/raddr; observes rdata/rvalid/busy
//   slave  : the memory side of the same signals
// ---------------------------------------------------------------------------
interface bm_param_memory_if #(
   parameter int unsigned WORD_SIZE = 4,
   parameter int unsigned ADDR_BITS = 2
) ();

   logic                 clear;
   logic                 we;
   logic [ADDR_BITS-1:0] waddr;
   logic [WORD_SIZE-1:0] wdata;
   logic                 re;
   logic [ADDR_BITS-1:0] raddr;
   logic [WORD_SIZE-1:0] rdata;
   logic                 rvalid;
   logic                 busy;

   modport master (
      output clear, we, waddr, wdata, re, raddr,
      input  rdata, rvalid, busy
   );

   modport slave (
      input  clear, we, waddr, wdata, re, raddr,
      output rdata, rvalid, busy
   );

endinterface

// File: rtl/bm_mem_clear_seq.sv
// ---------------------------------------------------------------------------
// bm_mem_clear_seq
// Two-state sequencer that sweeps every word of the array with zero after
// reset or on a clear request.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (restarts the sweep at word 0)
//   clear    : request a new sweep (honoured only when idle)
//   busy     : high while sweeping
//   clr_we   : write strobe for the array during the sweep
//   clr_addr : word being zeroed this cycle
// ---------------------------------------------------------------------------
module bm_mem_clear_seq
   import bm_memory_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 2,
   parameter int unsigned DEPTH     = 2**ADDR_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   output logic                 busy,
   output logic                 clr_we,
   output logic [ADDR_BITS-1:0] clr_addr
);

   // Wide enough to hold 2**ADDR_BITS, so a full-depth sweep never aliases.
   localparam int unsigned     CNT_W = clog2((2**ADDR_BITS) + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   logic             r_state;
   logic             w_state_d;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
         ST_CLEAR: begin
            if (r_cnt == LAST) begin
               w_state_d = ST_IDLE;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            if (clear) begin
               w_state_d = ST_CLEAR;
               w_cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   assign busy     = (r_state == ST_CLEAR);
   assign clr_we   = busy;
   assign clr_addr = r_cnt[ADDR_BITS-1:0];

endmodule

// File: rtl/bm_param_memory.sv
// ---------------------------------------------------------------------------
// bm_param_memory
// Parametrised register-file memory: one write port, one registered read
// port with a valid strobe, and a hardware zeroing sweep after reset/clear.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : bm_param_memory_if.slave (clear, we/waddr/wdata, re/raddr,
//           rdata/rvalid/busy)
// Build option:
//   BM_MEM_BYPASS_EN - same-cycle write/read of one in-range address returns
//                      the new write data instead of the old word.
// ---------------------------------------------------------------------------
module bm_param_memory
   import bm_memory_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 4,
   parameter int unsigned ADDR_BITS = 2,
   parameter int unsigned DEPTH     = 2**ADDR_BITS
) (
   input  logic              clock,
   input  logic              reset,
   bm_param_memory_if.slave  bus
);

   localparam logic [ADDR_BITS:0] DEPTH_V = (ADDR_BITS + 1)'(DEPTH);

   logic [WORD_SIZE-1:0] r_mem [DEPTH];
   logic [WORD_SIZE-1:0] r_rdata;
   logic                 r_rvalid;

   logic                 w_busy;
   logic                 w_clr_we;
   logic [ADDR_BITS-1:0] w_clr_addr;
   logic                 w_waddr_ok;
   logic                 w_raddr_ok;
   logic                 w_rd_en;
   logic [WORD_SIZE-1:0] w_rd_word;

   bm_mem_clear_seq #(
      .ADDR_BITS (ADDR_BITS),
      .DEPTH     (DEPTH)
   ) u_clear_seq (
      .clock    (clock),
      .reset    (reset),
      .clear    (bus.clear),
      .busy     (w_busy),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr)
   );

   assign w_waddr_ok = ({1'b0, bus.waddr} < DEPTH_V);
   assign w_raddr_ok = ({1'b0, bus.raddr} < DEPTH_V);
   assign w_rd_en    = bus.re & ~w_busy;

   // Out-of-range reads return zero rather than an undefined word.
   always_comb begin
      w_rd_word = '0;
      if (w_raddr_ok) begin
         w_rd_word = r_mem[bus.raddr];
`ifdef BM_MEM_BYPASS_EN
         if (bus.we && (bus.waddr == bus.raddr)) begin
            w_rd_word = bus.wdata;
         end
`endif
      end
   end

   // Array has no reset; the sweep port owns it while busy.
   always_ff @(posedge clock) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (bus.we && w_waddr_ok) begin
         r_mem[bus.waddr] <= bus.wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_rd_en;
         if (w_rd_en) begin
            r_rdata <= w_rd_word;
         end
      end
   end

   assign bus.rdata  = r_rdata;
   assign bus.rvalid = r_rvalid;
   assign bus.busy   = w_busy;

endmodule

// File: tb/tb_bm_param_memory.sv
// ---------------------------------------------------------------------------
// tb_bm_param_memory
// Scoreboard bench: the driver updates a behavioural memory model at each
// rising edge and queues the expected read word; a monitor pops and compares
// on every falling edge where rvalid is seen. A second DEPTH=3 instance
// covers the partially populated address space.
// ---------------------------------------------------------------------------
module tb_bm_param_memory;

   localparam int DEPTH = 4;
`ifdef BM_MEM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock;
   logic reset;

   bm_param_memory_if #(.WORD_SIZE(4), .ADDR_BITS(2)) bus  ();
   bm_param_memory_if #(.WORD_SIZE(4), .ADDR_BITS(2)) bus3 ();

   bm_param_memory #(
      .WORD_SIZE (4),
      .ADDR_BITS (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   bm_param_memory #(
      .WORD_SIZE (4),
      .ADDR_BITS (2),
      .DEPTH     (3)
   ) dut3 (
      .clock (clock),
      .reset (reset),
      .bus   (bus3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model
   logic [3:0] mem_m [DEPTH];
   int         busy_left;
   logic [3:0] expq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Effect of one rising edge, from the inputs held across it.
   task automatic model_edge();
      logic [3:0] v;
      if (busy_left > 0) begin
         mem_m[DEPTH - busy_left] = 4'h0;
         busy_left--;
      end else begin
         if (bus.re) begin
            v = mem_m[bus.raddr];
            if (BYP && bus.we && (bus.waddr == bus.raddr)) v = bus.wdata;
            expq.push_back(v);
         end
         if (bus.we) mem_m[bus.waddr] = bus.wdata;
         if (bus.clear) busy_left = DEPTH;
      end
   endtask

   task automatic cycle(input bit c, input bit w, input int wa, input int wd,
                        input bit r, input int ra);
      bus.clear = c;
      bus.we    = w;
      bus.waddr = 2'(wa);
      bus.wdata = 4'(wd);
      bus.re    = r;
      bus.raddr = 2'(ra);
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
   endtask

   task automatic cycle3(input bit w, input int wa, input int wd, input bit r, input int ra);
      bus3.we    = w;
      bus3.waddr = 2'(wa);
      bus3.wdata = 4'(wd);
      bus3.re    = r;
      bus3.raddr = 2'(ra);
      @(posedge clock);
      @(negedge clock);
   endtask

   // Monitor: busy against model, rdata against scoreboard on each rvalid.
   initial begin
      forever begin
         @(negedge clock);
         check("busy", 32'(bus.busy), 32'(busy_left > 0));
         if (bus.rvalid) begin
            if (expq.size() == 0) begin
               check("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
            end else begin
               check("rdata", 32'(bus.rdata), 32'(expq.pop_front()));
            end
         end else if (expq.size() != 0) begin
            check("missing_rvalid", 32'(bus.rvalid), 32'd1);
            expq.delete();
         end
      end
   end

   initial begin
      int sweep_start;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 4'h0;
      busy_left = DEPTH;
      {bus.clear, bus.we, bus.re} = 3'b000;
      bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
      {bus3.clear, bus3.we, bus3.re} = 3'b000;
      bus3.waddr = '0; bus3.wdata = '0; bus3.raddr = '0;

      // Reset state
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_rdata", 32'(bus.rdata), 32'd0);
      check("reset_rvalid", 32'(bus.rvalid), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;

      // Reads held during the sweep are ignored; busy for exactly DEPTH edges
      sweep_start = n_checks;
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, i);
      check("sweep_done", 32'(bus.busy), 32'd0);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, i);
      idle(1);

      // Write then read next cycle
      cycle(0, 1, 2, 'hA, 0, 0);
      cycle(0, 0, 0, 0, 1, 2);
      check("wr_rd_A", 32'(bus.rdata), 32'hA);
      idle(1);
      check("rvalid_one_cycle", 32'(bus.rvalid), 32'd0);

      // Same-cycle read and write of one address
      cycle(0, 1, 1, 'h3, 0, 0);
      cycle(0, 1, 1, 'h5, 1, 1);
      check("same_cycle_rw", 32'(bus.rdata), BYP ? 32'h5 : 32'h3);
      cycle(0, 0, 0, 0, 1, 1);
      check("after_rw", 32'(bus.rdata), 32'h5);

      // Fill, clear with writes attempted during the sweep, read back zeros
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, i, 'hF, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, i, 'h9, 1, i);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, i);
      check("post_clear_rd3", 32'(bus.rdata), 32'h0);

      // Reset mid-read: rvalid drops asynchronously
      cycle(0, 1, 0, 'h6, 0, 0);
      bus.we = 1'b0; bus.re = 1'b1; bus.raddr = 2'd0;
      @(posedge clock);
      model_edge();
      #2;
      check("pre_reset_rvalid", 32'(bus.rvalid), 32'd1);
      check("pre_reset_rdata", 32'(bus.rdata), 32'h6);
      expq.delete();
      reset = 1'b0;
      busy_left = DEPTH;
      #1;
      check("async_rvalid", 32'(bus.rvalid), 32'd0);
      check("async_rdata", 32'(bus.rdata), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      idle(DEPTH + 1);

      // Reset two cycles into a clear sweep restarts it at word 0
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, i, i + 1, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      idle(2);
      #2;
      reset = 1'b0;
      busy_left = DEPTH;
      #1;
      check("sweep_reset_rvalid", 32'(bus.rvalid), 32'd0);
      check("sweep_reset_rdata", 32'(bus.rdata), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      idle(DEPTH - 1);
      check("restart_still_busy", 32'(bus.busy), 32'd1);
      idle(1);
      check("restart_done", 32'(bus.busy), 32'd0);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, i);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 31) == 0, 1'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 15), 1'($urandom), $urandom_range(0, 3));
      end
      idle(DEPTH + 2);

      // DEPTH=3 instance: address 3 is outside the array
      check("d3_idle", 32'(bus3.busy), 32'd0);
      cycle3(1, 3, 'h7, 0, 0);
      cycle3(1, 2, 'h9, 0, 0);
      cycle3(0, 0, 0, 1, 3);
      check("d3_oob_rvalid", 32'(bus3.rvalid), 32'd1);
      check("d3_oob_rdata", 32'(bus3.rdata), 32'd0);
      cycle3(0, 0, 0, 1, 2);
      check("d3_rd2", 32'(bus3.rdata), 32'h9);
      cycle3(0, 0, 0, 1, 0);
      check("d3_rd0", 32'(bus3.rdata), 32'h0);
      cycle3(0, 0, 0, 0, 0);
      check("d3_rvalid_low", 32'(bus3.rvalid), 32'd0);

      if (n_checks <= sweep_start) check("checks_progress", 32'(n_checks), 32'(sweep_start + 1));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
